alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the main datapath and port 1 is an auxiliary unit such as a branch or address helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers the operands, drives the ALU for one cycle, then holds a registered result until the winner accepts it.
- It sits between the requesters and the Alu instance and replaces direct wiring of AluCtrl, DataIn1 and DataIn2.

Parameters:
DATA_W, 32, operand/result width
CTRL_W, 5, ALU control code width (AluCtrl encoding)
NOP_CODE, 5'd0, ALU control code driven when idle (ALUOp_NOP)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  CTRL_W  requester 0 ALU control code
req0_a  in  DATA_W  requester 0 operand 1
req0_b  in  DATA_W  requester 0 operand 2
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above for requester 1
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes result
rsp1_valid  out  1  result available for requester 1
rsp1_ready  in  1  requester 1 takes result
rsp_result  out  DATA_W  registered ALU result (shared by both response ports)
rsp_zero  out  1  registered ALU Zero flag
alu_ctrl  out  CTRL_W  to ALU AluCtrl
alu_in1  out  DATA_W  to ALU DataIn1
alu_in2  out  DATA_W  to ALU DataIn2
alu_result  in  DATA_W  from ALU AluResult
alu_zero  in  1  from ALU Zero
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, sampled when rst_n=0 at a clk edge:
  - state=IDLE, prio=0, grant=0.
  - Operand registers, rsp_result and rsp_zero are cleared to 0.
  - rsp0_valid=0 and rsp1_valid=0.
  - Any in-flight transaction is dropped and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and only ever asserted in IDLE.
  - Exactly one ready is high, and only if its valid is high.
  - Single requester valid: that requester wins.
  - Both valid: the requester equal to prio wins.
  - On handshake (valid & ready): capture op/a/b into registers, grant<=winner, state<=EXEC.
  - No valid: stay in IDLE.
- EXEC, one cycle:
  - alu_ctrl/alu_in1/alu_in2 are driven from the operand registers.
  - At the clock edge: rsp_result<=alu_result, rsp_zero<=alu_zero, state<=RESP.
- RESP:
  - rsp{grant}_valid=1; the other response valid=0.
  - rsp_result and rsp_zero are held stable.
  - Stays in RESP indefinitely while rsp{grant}_ready=0. The other requester's ready is ignored.
  - On rsp{grant}_ready=1: prio<=~grant, state<=IDLE. No new request is accepted in that same cycle.
- ALU outputs outside EXEC: alu_ctrl=NOP_CODE, alu_in1=0, alu_in2=0. This keeps the ALU quiescent; the ALU holds its last result on NOP.
- Latency: request handshake at edge T; alu_* driven in cycle T+1; rspN_valid from cycle T+2. Minimum occupancy is 3 cycles per operation.
- Arithmetic: the block never modifies data. Widths pass through unchanged, and op codes are forwarded verbatim, including undefined codes.
- Fairness: prio changes only when a response completes, never on request acceptance. Under continuous contention the requesters alternate 0,1,0,1.
- Stability: a requester dropping valid before ready has no effect. Operands are captured only on handshake, so later changes to reqN_* inputs do not affect an accepted operation.
- Outputs are glitch-free: valid, ready and alu_* depend only on state registers plus reqN_valid.

Test Plan:
- Reset then single op: req0 ADDU a=5 b=7 with rsp0_ready=1 -> req0_ready high in cycle 0; alu_ctrl=ADDU, alu_in1=5, alu_in2=7 in cycle 1; rsp0_valid with rsp_result=12, rsp_zero=0 in cycle 2; back to IDLE in cycle 3.
- Contention: both valid from reset, req0 SUBU 9-9, req1 OR 0xF0|0x0F -> req0 served first (rsp_result=0, rsp_zero=1); then req1 served (rsp_result=0xFF); then req0 again if it re-requests; grant order 0,1,0.
- Backpressure: rsp1_ready held 0 for 5 cycles after rsp1_valid -> rsp1_valid, rsp_result and busy stay stable; req0_ready stays 0 despite req0_valid=1; req0 is accepted in the cycle after rsp1_ready=1.
- Operand capture: change req0_a/req0_b in the cycle after handshake -> alu_in1/alu_in2 still show the captured values in EXEC.
- Reset mid-op: assert rst_n=0 during RESP -> next cycle rsp*_valid=0, busy=0, prio=0, rsp_result=0, alu_ctrl=NOP_CODE.
- Idle quiescence: no requests for 10 cycles -> alu_ctrl=NOP_CODE, alu_in1=0, alu_in2=0, both readys 0, busy=0.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Purpose: bundles the two requester channels, the shared response channel and
// the ALU-side wires of alu_share_arbiter.
// Modports:
//   slave  - the arbiter: takes requests and response-ready, drives ready/valid/result/ALU.
//   master - the requesters: drive requests and response-ready, observe the rest.
//   alu    - the combinational ALU: takes control/operands, returns result and zero flag.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 5
);
  // requester 0 (main datapath)
  logic              req0_valid;
  logic              req0_ready;
  logic [CTRL_W-1:0] req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  // requester 1 (auxiliary unit)
  logic              req1_valid;
  logic              req1_ready;
  logic [CTRL_W-1:0] req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  // responses
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  // ALU side
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  // status
  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    output alu_ctrl, alu_in1, alu_in2,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    input  busy
  );

  modport alu (
    input  alu_ctrl, alu_in1, alu_in2,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose: shares one combinational ALU between a main datapath requester (0)
// and an auxiliary requester (1). Round-robin arbitration in IDLE, operands
// registered on handshake, ALU driven for exactly one EXEC cycle, result held
// in RESP until the granted requester accepts it.
// Ports:
//   clk    - clock, all state updates on rising edge
//   rst_n  - synchronous active-low reset
//   bus    - alu_share_arbiter_if.slave: request/response channels, ALU wires, busy
module alu_share_arbiter #(
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      CTRL_W   = 5,
  parameter logic [CTRL_W-1:0] NOP_CODE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              prio;
  logic              grant;
  logic [CTRL_W-1:0] opReg;
  logic [DATA_W-1:0] aReg;
  logic [DATA_W-1:0] bReg;
  logic [DATA_W-1:0] resultReg;
  logic              zeroReg;

  logic              pick;
  logic              ready0;
  logic              ready1;
  logic              grantReady;

  // Winner selection: a lone requester wins, a tie goes to prio.
  assign pick = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;

  // Ready only in IDLE and only toward the selected, valid requester.
  assign ready0 = (state == IDLE) && bus.req0_valid && !pick;
  assign ready1 = (state == IDLE) && bus.req1_valid && pick;

  // Response-ready of the requester currently owning the result.
  assign grantReady = grant ? bus.rsp1_ready : bus.rsp0_ready;

  // Control and datapath state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      grant     <= 1'b0;
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      resultReg <= '0;
      zeroReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ready0 || ready1) begin
            opReg <= pick ? bus.req1_op : bus.req0_op;
            aReg  <= pick ? bus.req1_a  : bus.req0_a;
            bReg  <= pick ? bus.req1_b  : bus.req0_b;
            grant <= pick;
            state <= EXEC;
          end
        end
        EXEC: begin
          resultReg <= bus.alu_result;
          zeroReg   <= bus.alu_zero;
          state     <= RESP;
        end
        RESP: begin
          // Priority flips only when a response completes.
          if (grantReady) begin
            prio  <= ~grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU sees operands only in EXEC; NOP with zero operands otherwise.
  always_comb begin
    bus.alu_ctrl = NOP_CODE;
    bus.alu_in1  = '0;
    bus.alu_in2  = '0;
    if (state == EXEC) begin
      bus.alu_ctrl = opReg;
      bus.alu_in1  = aReg;
      bus.alu_in2  = bReg;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = (state == RESP) && !grant;
  assign bus.rsp1_valid = (state == RESP) && grant;
  assign bus.rsp_result = resultReg;
  assign bus.rsp_zero   = zeroReg;
  assign bus.busy       = (state != IDLE);

endmodule
